// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states and common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRequest,
    StSend,
    StAck,
    StRelease
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus clock fall detection.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clock_i,
  input  logic data_i,
  output logic clock_o,
  output logic data_o,
  output logic clock_fall_o
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  // Sync stages reset to 1, the idle level of an open-collector line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= clock_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= data_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  // A fall is the synced clock going from 1 on the previous cycle to 0 now.
  always_comb begin
    clock_o      = clk_sync_q;
    data_o       = dat_sync_q;
    clock_fall_o = clk_prev_q & ~clk_sync_q;
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 bits, ACK, release.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic           clk_in,
  input  logic           reset,
  ps2_host_tx_if.slave   tx_if,
  input  logic           ps2_clock_in,
  input  logic           ps2_data_in,
  output logic           ps2_clock_oe,
  output logic           ps2_data_oe,
  output logic           busy,
  output logic           done,
  output logic           ack_ok,
  output logic           error
);

  localparam int unsigned InhW = ($clog2(INHIBIT_CYCLES) > 0) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TmoW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

  ps2_state_e      state_q, state_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic [InhW-1:0] inhibit_cnt_q, inhibit_cnt_d;
  logic [TmoW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic            clock_oe_q, clock_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            ack_ok_q, ack_ok_d;
  logic            done_q, done_d;

  logic            clk_sync, dat_sync, clk_fall;
  logic            timeout_hit;
  logic [2:0]      bit_sel;

  ps2_line_sync u_sync (
    .clk_i        (clk_in),
    .rst_i        (reset),
    .clock_i      (ps2_clock_in),
    .data_i       (ps2_data_in),
    .clock_o      (clk_sync),
    .data_o       (dat_sync),
    .clock_fall_o (clk_fall)
  );

  assign bit_sel = bit_idx_q[2:0];

  // Timeout fires in the cycle the count since the last fall reaches TIMEOUT_CYCLES.
  assign timeout_hit = ((state_q == StSend) || (state_q == StAck) || (state_q == StRelease)) &&
                       (timeout_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    data_d        = data_q;
    parity_d      = parity_q;
    inhibit_cnt_d = inhibit_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    clock_oe_d    = clock_oe_q;
    data_oe_d     = data_oe_q;
    ack_ok_d      = ack_ok_q;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_if.tx_valid) begin
          data_d        = tx_if.tx_data;
          parity_d      = odd_parity(tx_if.tx_data);
          ack_ok_d      = 1'b0;
          inhibit_cnt_d = '0;
          clock_oe_d    = 1'b1;
          data_oe_d     = 1'b0;
          state_d       = StInhibit;
        end
      end
      StInhibit: begin
        if (inhibit_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = StRequest;
        end else begin
          inhibit_cnt_d = inhibit_cnt_q + 1'b1;
        end
      end
      StRequest: begin
        // Release the clock with data still low: that is the start bit.
        clock_oe_d    = 1'b0;
        bit_idx_d     = '0;
        timeout_cnt_d = '0;
        state_d       = StSend;
      end
      StSend: begin
        timeout_cnt_d = timeout_cnt_q + 1'b1;
        if (clk_fall) begin
          timeout_cnt_d = '0;
          bit_idx_d     = bit_idx_q + 1'b1;
          if (bit_idx_q < 4'd8) begin
            data_oe_d = ~data_q[bit_sel];
          end else if (bit_idx_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = StAck;
          end
        end
      end
      StAck: begin
        timeout_cnt_d = timeout_cnt_q + 1'b1;
        if (clk_fall) begin
          timeout_cnt_d = '0;
          ack_ok_d      = ~dat_sync;
          state_d       = StRelease;
        end
      end
      StRelease: begin
        timeout_cnt_d = timeout_cnt_q + 1'b1;
        if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout_hit) begin
      state_d    = StIdle;
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_idx_q     <= '0;
      data_q        <= '0;
      parity_q      <= 1'b0;
      inhibit_cnt_q <= '0;
      timeout_cnt_q <= '0;
      clock_oe_q    <= 1'b0;
      data_oe_q     <= 1'b0;
      ack_ok_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      data_q        <= data_d;
      parity_q      <= parity_d;
      inhibit_cnt_q <= inhibit_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      clock_oe_q    <= clock_oe_d;
      data_oe_q     <= data_oe_d;
      ack_ok_q      <= ack_ok_d;
      done_q        <= done_d;
    end
  end

  assign tx_if.tx_ready = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign ps2_clock_oe   = clock_oe_q;
  assign ps2_data_oe    = data_oe_q;
  assign done           = done_q;
  assign ack_ok         = ack_ok_q;
  assign error          = timeout_hit;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device plus table and random frames.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 50;
  localparam int TMO = 200;
  localparam int H   = 10;  // device clock half-period in system cycles

  logic clk = 1'b0;
  logic reset;
  logic dev_clk, dev_dat;
  logic ps2_clock_in, ps2_data_in, ps2_clock_oe, ps2_data_oe;
  logic busy, done, ack_ok, error;

  int n_cmp  = 0;
  int n_fail = 0;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in       (clk),
    .reset        (reset),
    .tx_if        (tx_if),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .busy         (busy),
    .done         (done),
    .ack_ok       (ack_ok),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Open-collector lines: either side can pull low.
  assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
  assign ps2_data_in  = dev_dat & ~ps2_data_oe;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_par;
  } vec_t;

  vec_t vecs[5];

  function automatic bit model_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One host frame driven by the device model; abort_at>0 stops right after that clock fall.
  task automatic run_frame(input logic [7:0] d, input bit ack, input bit exp_par,
                           input int abort_at, input bit hold);
    logic [9:0] rx;
    int cnt;
    bit seen;
    rx = '0;
    @(negedge clk);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    if (hold) tx_if.tx_data = ~d;
    else tx_if.tx_valid = 1'b0;
    cnt = 0;
    while (ps2_clock_oe && !ps2_data_oe && cnt < INH + 20) begin
      cnt++;
      @(negedge clk);
    end
    check("inhibit_len", cnt, INH);
    check("request_oe", {ps2_clock_oe, ps2_data_oe}, 2'b11);
    @(negedge clk);
    check("send_oe", {ps2_clock_oe, ps2_data_oe}, 2'b01);
    repeat (5) @(negedge clk);
    check("start_bit", ps2_data_in, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (k == abort_at) return;
      repeat (H) @(negedge clk);
      dev_clk   = 1'b1;
      rx[k - 1] = ps2_data_in;
      repeat (H) @(negedge clk);
    end
    check("data_bits", rx[7:0], d);
    check("parity_bit", rx[8], exp_par);
    check("stop_bit", rx[9], 1'b1);
    if (ack) dev_dat = 1'b0;
    @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (done) seen = 1'b1;
    end
    tx_if.tx_valid = 1'b0;
    check("done_seen", seen, 1'b1);
    check("ack_ok_at_done", ack_ok, ack);
    @(negedge clk);
    check("done_pulse_width", done, 1'b0);
    check("idle_after_done", {busy, tx_if.tx_ready}, 2'b01);
    repeat (3) @(negedge clk);
    check("ack_ok_held", ack_ok, ack);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    logic [7:0] rd;
    bit rack;

    vecs[0] = '{CMD_SET_LED, 1'b1, 1'b1};
    vecs[1] = '{8'h00,       1'b0, 1'b1};
    vecs[2] = '{CMD_RESET,   1'b1, 1'b1};
    vecs[3] = '{CMD_ENABLE,  1'b1, 1'b0};
    vecs[4] = '{CMD_ECHO,    1'b0, 1'b1};

    reset          = 1'b1;
    dev_clk        = 1'b1;
    dev_dat        = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {ps2_clock_oe, ps2_data_oe, busy, done, ack_ok, error, tx_if.tx_ready},
          7'b0000001);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, tx_if.tx_ready}, 2'b01);

    for (int i = 0; i < 5; i++) run_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_par, 0, 1'b0);

    // tx_valid held through a frame with different data: must not restart or recapture.
    run_frame(8'h5A, 1'b1, model_parity(8'h5A), 0, 1'b1);
    check("no_second_frame", busy, 1'b0);
    run_frame(8'hA5, 1'b1, model_parity(8'hA5), 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rd   = 8'($urandom);
      rack = 1'($urandom_range(0, 1));
      run_frame(rd, rack, model_parity(rd), 0, 1'b0);
    end

    // Device stops after fall 4: error lands TMO cycles after the synced fall (2 sync stages).
    run_frame(8'h3C, 1'b1, model_parity(8'h3C), 4, 1'b0);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < TMO + 50) begin
      @(negedge clk);
      cnt++;
      if (cnt == H) dev_clk = 1'b1;
      if (error) seen = 1'b1;
    end
    check("timeout_latency", cnt, TMO + 2);
    check("no_done_on_timeout", done, 1'b0);
    @(negedge clk);
    check("error_pulse_width", error, 1'b0);
    check("oe_after_timeout", {ps2_clock_oe, ps2_data_oe}, 2'b00);
    check("ready_after_timeout", tx_if.tx_ready, 1'b1);

    // Reset while the device holds fall 6.
    run_frame(CMD_SET_LED, 1'b1, 1'b1, 6, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_midframe", {ps2_clock_oe, ps2_data_oe, busy, done, ack_ok, tx_if.tx_ready},
          6'b000001);
    dev_clk = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(CMD_ENABLE, 1'b1, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000, clock-low hold in clk_in cycles (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum gap between device clock falls (20 ms at 100 MHz).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_in, input, 1 bit: 100 MHz system clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port tx_data, input, 8 bits: command byte to send to the device.
REQ-007 SHALL have port tx_valid, input, 1 bit: request to send tx_data.
REQ-008 SHALL have port tx_ready, output, 1 bit: high only in IDLE.
REQ-009 SHALL have ports ps2_clock_in and ps2_data_in, input, 1 bit each: raw line levels (asynchronous).
REQ-010 SHALL have ports ps2_clock_oe and ps2_data_oe, output, 1 bit each: 1 pulls the line low, 0 releases it.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE; the scancode receiver ignores the lines while it is high.
REQ-012 SHALL have ports done, ack_ok and error, output, 1 bit each: single-cycle completion pulse, device-ACK flag valid with done, and timeout pulse.

Function
REQ-013 SHALL register the line inputs through a 2-FF synchronizer; a fall SHALL be synced clock previous=1, current=0.
REQ-014 SHALL capture tx_data and enter INHIBIT on a cycle where tx_valid and tx_ready are both high.
REQ-015 SHALL ignore tx_valid when tx_ready is low, with no queueing.
REQ-016 INHIBIT: clock_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQUEST.
REQ-017 REQUEST: clock_oe=1, data_oe=1 for 1 cycle, then go to SEND.
REQ-018 SEND: clock_oe=0 and data_oe=1 (start bit), with bit index 0.
REQ-019 In SEND, on each fall, index n SHALL increment.
- Falls 1..8: data_oe = ~tx_data[n-1], LSB first.
- Fall 9: data_oe = ~parity, where parity = ~^tx_data (odd).
- Fall 10: data_oe = 0 (stop bit); go to ACK.
REQ-020 Each data_oe update SHALL occur on the cycle after the fall is detected.
REQ-021 ACK: on the next fall, latch ack_ok = ~synced data; go to RELEASE.
REQ-022 RELEASE: wait until synced clock and data are both high, then pulse done for 1 cycle and return to IDLE.
REQ-023 ack_ok SHALL hold its value until the next accepted request.
REQ-024 A timeout counter SHALL clear on entry to SEND and on every fall.
REQ-025 If the timeout counter reaches TIMEOUT_CYCLES in SEND, ACK or RELEASE:
- pulse error for 1 cycle;
- drive both oe signals to 0;
- go to IDLE with no done pulse.
REQ-026 The parity register SHALL be 1 bit and the bit index 4 bits; the timeout and inhibit counters SHALL be sized by $clog2 of their parameters.
REQ-027 Device clock falls in IDLE or INHIBIT SHALL have no effect.

Reset
REQ-028 Reset SHALL force IDLE and set ps2_clock_oe=0, ps2_data_oe=0, busy=0, done=0, ack_ok=0, error=0, tx_ready=1, with all counters cleared.
REQ-029 Asserting reset mid-frame SHALL release both lines in the first cycle after the reset edge.
REQ-030 Reset SHALL also clear the synchronizer flops to 1 (idle line level).

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum (IDLE, INHIBIT, REQUEST, SEND, ACK, RELEASE) and the command constants CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
REQ-032 Sub-module ps2_line_sync SHALL provide the 2-FF synchronizer and fall detector; the keyboard receiver may share it.

Verification
REQ-033 Send 8'hED with a device model at 12.5 kHz: clock held low ≥12000 cycles, then bits 1,0,1,1,0,1,1,1, parity 1 (ones count 6 is even), stop 1; model ACKs low -> done=1, ack_ok=1.
REQ-034 Send 8'h00: parity bit = 1, all data bits low; model omits the ACK (data high) -> done=1, ack_ok=0.
REQ-035 Model stops clocking after fall 4 -> error pulses exactly TIMEOUT_CYCLES cycles after fall 4; oe=0; tx_ready=1 the next cycle.
REQ-036 Assert reset at fall 6 of a frame -> ps2_clock_oe=ps2_data_oe=0 and busy=0 in the first cycle after reset.
REQ-037 Second tx_valid held high while busy -> ignored; one frame only; the next request is accepted only after done.
REQ-038 Send 8'hFF -> parity bit 1 (odd total) and correct bit sequence.
